// File: rtl/floo_pkg.sv
// Shared types and helpers for the virtual-channel receive buffer.
// Optional feature macro used by the top: FLOO_VC_RX_ERR_EN (sticky multi-valid error flag).
package floo_pkg;

    // Upper bound on the number of virtual channels the helpers accept.
    localparam int unsigned MaxVirtChannels = 32;

    // Virtual-channel index wide enough for the largest supported configuration.
    typedef logic [$clog2(MaxVirtChannels)-1:0] vc_id_t;

    // True when more than one bit of the vector is set. Zero or one set bit is legal.
    function automatic logic is_multi_hot(input logic [MaxVirtChannels-1:0] vec);
        return (vec & (vec - MaxVirtChannels'(1))) != '0;
    endfunction

endpackage

// File: rtl/floo_rx_fifo.sv
// Single virtual-channel FIFO: explicit-wrap pointers (any Depth >= 1),
// occupancy counter, no fall-through path from push to read data.
module floo_rx_fifo
    import floo_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         flit_t = logic
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  flit_t                      wdata,
    input  logic                       pop,
    output flit_t                      rdata,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count_q;
    flit_t           mem [Depth];

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    // Guards make a push into a full FIFO or a pop from an empty one a no-op.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy state; pointers wrap at Depth-1 so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/floo_vc_rx_buffer.sv
// Receive end of a virtual-channel link: demultiplexes one shared flit bus into
// per-VC FIFOs so that backpressure on one VC never stalls another.
// Optional feature macro: FLOO_VC_RX_ERR_EN enables the sticky err_o flag and a
// simulation check for more than one valid_i bit in a cycle; otherwise err_o is 0.
//
// Handshake: a transfer on a channel happens at a rising edge where both valid and
// ready are high. ready_o depends only on stored FIFO occupancy (never on valid_i or
// ready_i); valid_o/data_o are held stable by the FIFO until the matching ready_i.
module floo_vc_rx_buffer
    import floo_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 1,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic [NumVirtChannels-1:0] valid_o,
    input  logic [NumVirtChannels-1:0] ready_i,
    output flit_t                      data_o [NumVirtChannels],
    output logic                       err_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
        logic [CntW-1:0] count;
        logic            vc_ready;
        logic            vc_valid;

        // Ready/valid come straight from the registered occupancy of this VC.
        assign vc_ready   = (count != CntW'(Depth));
        assign vc_valid   = (count != '0);
        assign ready_o[v] = vc_ready;
        assign valid_o[v] = vc_valid;

        floo_rx_fifo #(
            .Depth  (Depth),
            .flit_t (flit_t)
        ) i_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (valid_i[v] & vc_ready),
            .wdata (data_i),
            .pop   (vc_valid & ready_i[v]),
            .rdata (data_o[v]),
            .count (count)
        );
    end

`ifdef FLOO_VC_RX_ERR_EN
    logic err_q;
    logic multi_hot;

    assign multi_hot = is_multi_hot(MaxVirtChannels'(valid_i));

    // Sticky error: any cycle with several valid bits latches err until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    multi_valid_chk : assert property (@(posedge clk_i) disable iff (rst_i) !multi_hot)
        else $warning("floo_vc_rx_buffer: more than one valid_i bit set");
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_vc_rx_buffer.sv
// Bench for floo_vc_rx_buffer: a 2-VC/depth-2 instance and a 2-VC/depth-3 instance,
// each compared every cycle against per-VC queue models.
module tb_floo_vc_rx_buffer;

    typedef logic [7:0] flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // depth-2 instance
    logic [1:0] valid_i = '0;
    logic [1:0] ready_i = '0;
    flit_t      data_i  = '0;
    logic [1:0] valid_o;
    logic [1:0] ready_o;
    flit_t      data_o [2];
    logic       err_o;

    // depth-3 instance
    logic [1:0] valid3_i = '0;
    logic [1:0] ready3_i = '0;
    flit_t      data3_i  = '0;
    logic [1:0] valid3_o;
    logic [1:0] ready3_o;
    flit_t      data3_o [2];
    logic       err3_o;

    flit_t exp_q  [2][$];
    flit_t exp3_q [2][$];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FLOO_VC_RX_ERR_EN
    localparam logic ErrOnMulti = 1'b1;
`else
    localparam logic ErrOnMulti = 1'b0;
`endif

    floo_vc_rx_buffer #(.NumVirtChannels(2), .Depth(2), .flit_t(flit_t)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .err_o(err_o)
    );

    floo_vc_rx_buffer #(.NumVirtChannels(2), .Depth(3), .flit_t(flit_t)) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid3_i), .ready_o(ready3_o), .data_i(data3_i),
        .valid_o(valid3_o), .ready_i(ready3_i), .data_o(data3_o), .err_o(err3_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock: update the queue models with the handshakes of this edge.
    task automatic tick();
        for (int v = 0; v < 2; v++) begin
            if (rst) begin
                exp_q[v].delete();
                exp3_q[v].delete();
            end else begin
                bit can_push;
                bit can_push3;
                can_push  = exp_q[v].size() < 2;
                can_push3 = exp3_q[v].size() < 3;
                if (exp_q[v].size() > 0 && ready_i[v]) void'(exp_q[v].pop_front());
                if (valid_i[v] && can_push) exp_q[v].push_back(data_i);
                if (exp3_q[v].size() > 0 && ready3_i[v]) void'(exp3_q[v].pop_front());
                if (valid3_i[v] && can_push3) exp3_q[v].push_back(data3_i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_valid();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (exp_q[v].size() != 0);
        return r;
    endfunction

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (exp_q[v].size() != 2);
        return r;
    endfunction

    function automatic logic [1:0] model3_valid();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (exp3_q[v].size() != 0);
        return r;
    endfunction

    function automatic logic [1:0] model3_ready();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (exp3_q[v].size() != 3);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_i = 2'b01; data_i = 8'hAA; ready_i = 2'b00;
        valid3_i = 2'b10; data3_i = 8'hBB; ready3_i = 2'b00;
        repeat (3) tick();
        n_tests++;
        if (valid_o !== 2'b00) begin n_fail++; $display("FAIL reset valid_o: got %b want 00", valid_o); end
        n_tests++;
        if (ready_o !== 2'b11) begin n_fail++; $display("FAIL reset ready_o: got %b want 11", ready_o); end
        n_tests++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset err_o: got %b want 0", err_o); end
        n_tests++;
        if (ready3_o !== 2'b11 || valid3_o !== 2'b00) begin
            n_fail++; $display("FAIL reset dut3: ready %b valid %b want 11/00", ready3_o, valid3_o);
        end
        rst = 1'b0; valid_i = 2'b00; valid3_i = 2'b00;
        tick();
        n_tests++;
        if (valid_o !== 2'b00 || valid3_o !== 2'b00) begin
            n_fail++; $display("FAIL reset no_push: valid_o %b valid3_o %b want 00", valid_o, valid3_o);
        end
    endtask

    task automatic test_stream();
        ready_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            flit_t want;
            want    = 8'h10 + flit_t'(i);
            valid_i = 2'b01;
            data_i  = want;
            tick();
            n_tests++;
            if (valid_o[0] !== 1'b1 || data_o[0] !== want) begin
                n_fail++; $display("FAIL stream flit%0d: valid %b data %h want 1 %h", i, valid_o[0], data_o[0], want);
            end
            n_tests++;
            if (ready_o !== 2'b11 || valid_o !== model_valid()) begin
                n_fail++; $display("FAIL stream rdy%0d: ready %b valid %b want 11 %b", i, ready_o, valid_o, model_valid());
            end
        end
        valid_i = 2'b00;
        tick();
        n_tests++;
        if (valid_o !== 2'b00) begin n_fail++; $display("FAIL stream drain: valid_o %b want 00", valid_o); end
    endtask

    task automatic test_isolation();
        ready_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            valid_i = 2'b01; data_i = 8'hA0 + flit_t'(i);
            tick();
        end
        n_tests++;
        if (ready_o[0] !== 1'b0 || data_o[0] !== 8'hA0) begin
            n_fail++; $display("FAIL iso vc0_full: ready %b head %h want 0 a0", ready_o[0], data_o[0]);
        end
        ready_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            flit_t want;
            want = 8'hB0 + flit_t'(i);
            valid_i = 2'b10; data_i = want;
            tick();
            n_tests++;
            if (valid_o[1] !== 1'b1 || data_o[1] !== want || ready_o[1] !== 1'b1) begin
                n_fail++; $display("FAIL iso vc1_%0d: valid %b data %h ready %b want 1 %h 1", i, valid_o[1], data_o[1], ready_o[1], want);
            end
            n_tests++;
            if (ready_o[0] !== 1'b0 || data_o[0] !== 8'hA0) begin
                n_fail++; $display("FAIL iso vc0_hold%0d: ready %b head %h want 0 a0", i, ready_o[0], data_o[0]);
            end
        end
        valid_i = 2'b00;
        tick();
        n_tests++;
        if (valid_o !== 2'b01) begin n_fail++; $display("FAIL iso vc1_drained: valid_o %b want 01", valid_o); end
        ready_i = 2'b01;
        tick();
        n_tests++;
        if (valid_o[0] !== 1'b1 || data_o[0] !== 8'hA1) begin
            n_fail++; $display("FAIL iso vc0_release: valid %b head %h want 1 a1", valid_o[0], data_o[0]);
        end
        tick();
        n_tests++;
        if (valid_o !== model_valid() || valid_o !== 2'b00) begin
            n_fail++; $display("FAIL iso vc0_empty: valid_o %b want 00", valid_o);
        end
    endtask

    task automatic test_full_pop();
        ready_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            valid_i = 2'b01; data_i = 8'hC0 + flit_t'(i);
            tick();
        end
        n_tests++;
        if (ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL fullpop full: ready %b want 0", ready_o[0]); end
        ready_i = 2'b01; valid_i = 2'b01; data_i = 8'hEE;
        tick();
        n_tests++;
        if (ready_o[0] !== 1'b1 || valid_o[0] !== 1'b1 || data_o[0] !== 8'hC1) begin
            n_fail++; $display("FAIL fullpop next: ready %b valid %b head %h want 1 1 c1", ready_o[0], valid_o[0], data_o[0]);
        end
        valid_i = 2'b00;
        tick();
        n_tests++;
        if (valid_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL fullpop blocked: valid %b head %h want 0 (ee not stored)", valid_o[0], data_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            int sel;
            int sel3;
            sel  = $urandom_range(0, 2);
            sel3 = $urandom_range(0, 2);
            valid_i  = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b10);
            valid3_i = (sel3 == 0) ? 2'b00 : ((sel3 == 1) ? 2'b01 : 2'b10);
            data_i   = flit_t'($urandom);
            data3_i  = flit_t'($urandom);
            ready_i  = 2'($urandom_range(0, 3));
            ready3_i = 2'($urandom_range(0, 3));
            tick();
            n_tests++;
            if (valid_o !== model_valid() || ready_o !== model_ready()) begin
                n_fail++; $display("FAIL random d2 c%0d: valid %b ready %b want %b %b", c, valid_o, ready_o, model_valid(), model_ready());
            end
            n_tests++;
            if (valid3_o !== model3_valid() || ready3_o !== model3_ready()) begin
                n_fail++; $display("FAIL random d3 c%0d: valid %b ready %b want %b %b", c, valid3_o, ready3_o, model3_valid(), model3_ready());
            end
            for (int v = 0; v < 2; v++) begin
                if (exp_q[v].size() > 0) begin
                    n_tests++;
                    if (data_o[v] !== exp_q[v][0]) begin
                        n_fail++; $display("FAIL random d2 data c%0d vc%0d: got %h want %h", c, v, data_o[v], exp_q[v][0]);
                    end
                end
                if (exp3_q[v].size() > 0) begin
                    n_tests++;
                    if (data3_o[v] !== exp3_q[v][0]) begin
                        n_fail++; $display("FAIL random d3 data c%0d vc%0d: got %h want %h", c, v, data3_o[v], exp3_q[v][0]);
                    end
                end
            end
        end
        valid_i = 2'b00; valid3_i = 2'b00;
    endtask

    task automatic test_err();
        rst = 1'b1; ready_i = 2'b00; valid_i = 2'b00;
        tick();
        rst = 1'b0;
        valid_i = 2'b11; data_i = 8'h5A;
        tick();
        valid_i = 2'b00;
        n_tests++;
        if (err_o !== ErrOnMulti) begin n_fail++; $display("FAIL err set: got %b want %b", err_o, ErrOnMulti); end
        n_tests++;
        if (valid_o !== 2'b11 || data_o[0] !== 8'h5A || data_o[1] !== 8'h5A) begin
            n_fail++; $display("FAIL err dup: valid %b data %h %h want 11 5a 5a", valid_o, data_o[0], data_o[1]);
        end
        repeat (3) tick();
        n_tests++;
        if (err_o !== ErrOnMulti) begin n_fail++; $display("FAIL err sticky: got %b want %b", err_o, ErrOnMulti); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (err_o !== 1'b0 || valid_o !== 2'b00 || ready_o !== 2'b11) begin
            n_fail++; $display("FAIL err clear: err %b valid %b ready %b want 0 00 11", err_o, valid_o, ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_isolation();
        test_full_pop();
        test_random();
        test_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
